// File: rtl/exe_trace_pkg.sv
// Shared types and counter widths for the execution-trace checker.
package exe_trace_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  localparam int LINE_CNT_WIDTH     = 32;
  localparam int MISMATCH_CNT_WIDTH = 16;

endpackage

// File: rtl/exe_trace_checker_trace_fifo.sv
// Single-clock FIFO holding retired-instruction records awaiting comparison.
// Head is read from the array without a register so a record pushed at edge N is comparable at N+1.
module trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/exe_trace_checker.sv
// Compares buffered actual trace records against a streamed expected trace.
// Optional first-failure capture ports are enabled by EXE_TRACE_FIRST_FAIL_CAPTURE_EN.
module exe_trace_checker
  import exe_trace_pkg::*;
#(
  parameter int NUM_OF_COLUMNS = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int NUM_OF_LINES   = 0
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 enable_in,
  input  logic [NUM_OF_COLUMNS*DATA_WIDTH-1:0] data_to_cmp,
  input  logic                                 exp_valid,
  input  logic [NUM_OF_COLUMNS*DATA_WIDTH-1:0] exp_data,
  input  logic [NUM_OF_COLUMNS-1:0]            exp_mask,
  input  logic                                 exp_last,
  output logic                                 exp_ready,
  output logic                                 halt_req,
  input  logic                                 resume,
  output logic                                 pass1_fail0,
  output logic                                 all_done,
  output logic [LINE_CNT_WIDTH-1:0]            line_cnt,
  output logic [MISMATCH_CNT_WIDTH-1:0]        mismatch_cnt,
  output logic                                 overflow
`ifdef EXE_TRACE_FIRST_FAIL_CAPTURE_EN
  ,
  output logic [LINE_CNT_WIDTH-1:0]            first_fail_line,
  output logic [NUM_OF_COLUMNS*DATA_WIDTH-1:0] first_fail_data
`endif
);

  localparam int RW = NUM_OF_COLUMNS * DATA_WIDTH;
  localparam logic [LINE_CNT_WIDTH-1:0]     LINE_ONE    = 1;
  localparam logic [MISMATCH_CNT_WIDTH-1:0] MCNT_ONE    = 1;
  localparam logic [LINE_CNT_WIDTH-1:0]     LINES_LIMIT = LINE_CNT_WIDTH'(NUM_OF_LINES);

  chk_state_e                    state_q, state_d;
  logic                          halt_q, halt_d;
  logic                          pass_q, pass_d;
  logic                          done_q, done_d;
  logic                          ovf_q, ovf_d;
  logic [LINE_CNT_WIDTH-1:0]     line_q, line_d;
  logic [MISMATCH_CNT_WIDTH-1:0] mcnt_q, mcnt_d;

  logic                      fifo_full, fifo_empty;
  logic [RW-1:0]             fifo_head;
  logic                      push_req, pop, overflow_evt;
  logic [NUM_OF_COLUMNS-1:0] col_diff;
  logic                      mismatch, last_rec;
  logic [LINE_CNT_WIDTH-1:0] line_inc;

  trace_fifo #(
    .WIDTH (RW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_req),
    .push_data (data_to_cmp),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OF_COLUMNS; gi++) begin : g_col
      assign col_diff[gi] = !exp_mask[gi] &&
        (fifo_head[gi*DATA_WIDTH +: DATA_WIDTH] != exp_data[gi*DATA_WIDTH +: DATA_WIDTH]);
    end
  endgenerate

  assign pop          = (state_q == ST_RUN) && !fifo_empty && exp_valid;
  assign push_req     = enable_in && (state_q != ST_DONE);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is then legal.
  assign overflow_evt = push_req && fifo_full && !pop;
  assign mismatch     = |col_diff;
  assign line_inc     = line_q + LINE_ONE;
  assign last_rec     = exp_last || ((NUM_OF_LINES != 0) && (line_inc == LINES_LIMIT));

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    pass_d  = pass_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    line_d  = line_q;
    mcnt_d  = mcnt_q;
    if ((state_q == ST_HALT) && resume) begin
      state_d = ST_RUN;
      halt_d  = 1'b0;
    end
    if (pop) begin
      line_d = line_inc;
      if (mismatch) begin
        pass_d = 1'b0;
        if (mcnt_q != '1) mcnt_d = mcnt_q + MCNT_ONE;
      end
      // Final record ends checking even when it mismatches; nothing is left to resume.
      if (last_rec) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else if (mismatch) begin
        state_d = ST_HALT;
        halt_d  = 1'b1;
      end
    end
    if (overflow_evt) begin
      ovf_d   = 1'b1;
      halt_d  = 1'b1;
      pass_d  = 1'b0;
      state_d = ST_HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      halt_q  <= 1'b0;
      pass_q  <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      line_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      line_q  <= line_d;
      mcnt_q  <= mcnt_d;
    end
  end

  assign exp_ready    = pop;
  assign halt_req     = halt_q;
  assign pass1_fail0  = pass_q;
  assign all_done     = done_q;
  assign overflow     = ovf_q;
  assign line_cnt     = line_q;
  assign mismatch_cnt = mcnt_q;

`ifdef EXE_TRACE_FIRST_FAIL_CAPTURE_EN
  // Captures the line number (1-based) and actual record of the first mismatch only.
  logic                      ff_taken_q, ff_taken_d;
  logic [LINE_CNT_WIDTH-1:0] ff_line_q, ff_line_d;
  logic [RW-1:0]             ff_data_q, ff_data_d;

  always_comb begin
    ff_taken_d = ff_taken_q;
    ff_line_d  = ff_line_q;
    ff_data_d  = ff_data_q;
    if (pop && mismatch && !ff_taken_q) begin
      ff_taken_d = 1'b1;
      ff_line_d  = line_inc;
      ff_data_d  = fifo_head;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ff_taken_q <= 1'b0;
      ff_line_q  <= '0;
      ff_data_q  <= '0;
    end else begin
      ff_taken_q <= ff_taken_d;
      ff_line_q  <= ff_line_d;
      ff_data_q  <= ff_data_d;
    end
  end

  assign first_fail_line = ff_line_q;
  assign first_fail_data = ff_data_q;
`endif

endmodule

// File: tb/tb_exe_trace_checker.sv
// Directed and randomized checks of exe_trace_checker against a queue-based reference model.
module tb_exe_trace_checker;

  localparam int NC = 2;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int RW = NC * W;

  logic          clk = 1'b0;
  logic          reset_n, enable_in, exp_valid, exp_last, resume;
  logic [RW-1:0] data_to_cmp, exp_data;
  logic [NC-1:0] exp_mask;

  logic        a_ready, a_halt, a_pass, a_done, a_ovf;
  logic [31:0] a_line;
  logic [15:0] a_mcnt;
  logic        b_ready, b_halt, b_pass, b_done, b_ovf;
  logic [31:0] b_line;
  logic [15:0] b_mcnt;

  always #5 clk = ~clk;

  exe_trace_checker #(.NUM_OF_COLUMNS(NC), .DATA_WIDTH(W), .FIFO_DEPTH(D), .NUM_OF_LINES(0)) dut (
    .clk(clk), .reset_n(reset_n), .enable_in(enable_in), .data_to_cmp(data_to_cmp),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_mask(exp_mask), .exp_last(exp_last),
    .exp_ready(a_ready), .halt_req(a_halt), .resume(resume), .pass1_fail0(a_pass),
    .all_done(a_done), .line_cnt(a_line), .mismatch_cnt(a_mcnt), .overflow(a_ovf));

  exe_trace_checker #(.NUM_OF_COLUMNS(NC), .DATA_WIDTH(W), .FIFO_DEPTH(D), .NUM_OF_LINES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .enable_in(enable_in), .data_to_cmp(data_to_cmp),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_mask(exp_mask), .exp_last(exp_last),
    .exp_ready(b_ready), .halt_req(b_halt), .resume(resume), .pass1_fail0(b_pass),
    .all_done(b_done), .line_cnt(b_line), .mismatch_cnt(b_mcnt), .overflow(b_ovf));

  // sel picks which instance the model is tracking.
  bit          sel = 1'b0;
  logic        o_ready, o_halt, o_pass, o_done, o_ovf;
  logic [31:0] o_line;
  logic [15:0] o_mcnt;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_halt  = sel ? b_halt  : a_halt;
  assign o_pass  = sel ? b_pass  : a_pass;
  assign o_done  = sel ? b_done  : a_done;
  assign o_ovf   = sel ? b_ovf   : a_ovf;
  assign o_line  = sel ? b_line  : a_line;
  assign o_mcnt  = sel ? b_mcnt  : a_mcnt;

  int total = 0;
  int bad   = 0;

  // Reference model: state 0=checking, 1=halted, 2=finished.
  logic [RW-1:0] m_q[$];
  int  m_state, m_mcnt, m_nl;
  bit  m_halt, m_pass, m_done, m_ovf;
  longint m_line;
  bit  rst_n;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state = 0; m_halt = 0; m_pass = 1; m_done = 0; m_ovf = 0;
    m_line = 0; m_mcnt = 0;
  endtask

  task automatic step(input bit en, input logic [RW-1:0] d, input bit ev,
                      input logic [RW-1:0] ed, input logic [NC-1:0] em,
                      input bit el, input bit res);
    bit m_rdy, mis, last;
    int pre;
    logic [RW-1:0] rec;
    reset_n = rst_n; enable_in = en; data_to_cmp = d; exp_valid = ev;
    exp_data = ed; exp_mask = em; exp_last = el; resume = res;
    #1;
    m_rdy = (m_state == 0) && (m_q.size() > 0) && ev;
    chk("exp_ready", o_ready, m_rdy);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      pre = m_state;
      if (pre == 1 && res) begin m_state = 0; m_halt = 0; end
      if (m_rdy) begin
        rec = m_q.pop_front();
        mis = 0;
        for (int c = 0; c < NC; c++)
          if (!em[c] && rec[c*W +: W] != ed[c*W +: W]) mis = 1;
        m_line++;
        if (mis) begin
          if (m_mcnt < 65535) m_mcnt++;
          m_pass = 0;
        end
        last = el || (m_nl != 0 && m_line == m_nl);
        if (last) begin m_state = 2; m_done = 1; end
        else if (mis) begin m_state = 1; m_halt = 1; end
        $display("txn line=%0d act=%h exp=%h mask=%b diff=%0d last=%0d", m_line, rec, ed, em, mis, last);
      end
      if (en && pre != 2) begin
        if (m_q.size() < D) m_q.push_back(d);
        else begin m_ovf = 1; m_halt = 1; m_pass = 0; m_state = 1; end
      end
    end
    #1;
    chk("halt_req", o_halt, m_halt);
    chk("pass1_fail0", o_pass, m_pass);
    chk("all_done", o_done, m_done);
    chk("overflow", o_ovf, m_ovf);
    chk("line_cnt", o_line, m_line[31:0]);
    chk("mismatch_cnt", o_mcnt, m_mcnt[15:0]);
  endtask

  function automatic logic [RW-1:0] mkrec(input int pc, input logic [31:0] ir);
    logic [31:0] p;
    p = pc;
    return {ir, p};
  endfunction

  task automatic do_reset();
    rst_n = 0;
    step(0, '0, 0, '0, '0, 0, 0);
    rst_n = 1;
  endtask

  logic [RW-1:0] recs[10];

  initial begin
    rst_n = 0; m_nl = 0;
    model_reset();
    reset_n = 0; enable_in = 0; data_to_cmp = '0; exp_valid = 0;
    exp_data = '0; exp_mask = '0; exp_last = 0; resume = 0;
    @(posedge clk); #1;
    do_reset();
    chk("rst_line", o_line, 32'd0);
    chk("rst_pass", o_pass, 1'b1);

    for (int i = 0; i < 10; i++) recs[i] = mkrec(32'h100 + 4*i, 32'h00000013 + 32'(i << 8));

    // All-equal run of four records ending on exp_last.
    for (int i = 0; i < 4; i++) step(1, recs[i], 0, '0, '0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, recs[i], '0, i == 3, 0);
    chk("t1_line", o_line, 32'd4);
    chk("t1_mcnt", o_mcnt, 16'd0);
    chk("t1_pass", o_pass, 1'b1);
    chk("t1_done", o_done, 1'b1);

    // IR mismatch on record 2, halt, then resume.
    do_reset();
    recs[1] = mkrec(32'h104, 32'h00000093);
    for (int i = 0; i < 4; i++) step(1, recs[i], 0, '0, '0, 0, 0);
    step(0, '0, 1, recs[0], '0, 0, 0);
    step(0, '0, 1, mkrec(32'h104, 32'h00000013), '0, 0, 0);
    chk("t2_mcnt", o_mcnt, 16'd1);
    chk("t2_pass", o_pass, 1'b0);
    chk("t2_halt", o_halt, 1'b1);
    step(0, '0, 1, recs[2], '0, 0, 0);
    chk("t2_no_pop_line", o_line, 32'd2);
    step(0, '0, 0, '0, '0, 0, 1);
    chk("t2_resumed", o_halt, 1'b0);
    step(0, '0, 1, recs[2], '0, 0, 0);
    step(0, '0, 1, recs[3], '0, 1, 0);
    chk("t2_line", o_line, 32'd4);
    chk("t2_done", o_done, 1'b1);

    // Same IR difference, IR column masked.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, recs[i], 0, '0, '0, 0, 0);
    step(0, '0, 1, recs[0], 2'b00, 0, 0);
    step(0, '0, 1, mkrec(32'h104, 32'h00000013), 2'b10, 0, 0);
    chk("t3_mcnt", o_mcnt, 16'd0);
    chk("t3_pass", o_pass, 1'b1);

    // Overflow: depth+1 pushes, then drain in order.
    do_reset();
    for (int i = 0; i <= D; i++) step(1, recs[i], 0, '0, '0, 0, 0);
    chk("t4_ovf", o_ovf, 1'b1);
    chk("t4_halt", o_halt, 1'b1);
    step(0, '0, 0, '0, '0, 0, 1);
    for (int i = 0; i < D; i++) step(0, '0, 1, recs[i], '0, i == D-1, 0);
    chk("t4_order_mcnt", o_mcnt, 16'd0);
    chk("t4_line", o_line, 32'(D));

    // Line-limited instance: done after the third compare, no exp_last.
    do_reset();
    sel = 1; m_nl = 3;
    for (int i = 0; i < 4; i++) step(1, recs[i], 0, '0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, recs[i], '0, 0, 0);
    chk("t5_done", o_done, 1'b1);
    step(1, recs[5], 1, recs[3], '0, 0, 0);
    chk("t5_ready_after", o_ready, 1'b0);
    do_reset();
    sel = 0; m_nl = 0;

    // Reset while halted with three records buffered.
    for (int i = 0; i < 4; i++) step(1, recs[i], 0, '0, '0, 0, 0);
    step(0, '0, 1, mkrec(0, 0), '0, 0, 0);
    chk("t6_halt", o_halt, 1'b1);
    do_reset();
    chk("t6_line", o_line, 32'd0);
    chk("t6_halt_rst", o_halt, 1'b0);
    step(0, '0, 1, recs[0], '0, 0, 0);
    chk("t6_empty", o_ready, 1'b0);
    step(1, recs[0], 0, '0, '0, 0, 0);
    step(0, '0, 1, recs[0], '0, 0, 0);
    chk("t6_run_line", o_line, 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      bit en, ev, el, res;
      logic [RW-1:0] d, ed;
      logic [NC-1:0] em;
      en  = ($urandom_range(0, 2) != 0);
      d   = {28'h0, 4'($urandom), 28'h0, 4'($urandom)};
      ev  = ($urandom_range(0, 2) != 0);
      if (m_q.size() > 0 && $urandom_range(0, 7) != 0) ed = m_q[0];
      else ed = {28'h0, 4'($urandom), 28'h0, 4'($urandom)};
      em  = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '0;
      el  = ($urandom_range(0, 59) == 0);
      res = ($urandom_range(0, 3) == 0);
      rst_n = !(m_state == 2 || $urandom_range(0, 299) == 0);
      step(en, d, ev, ed, em, el, res);
    end
    rst_n = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
